// File: rtl/pll_clk_en_pkg.sv
// rtl/pll_clk_en_pkg.sv - shared types, defaults and helpers for the clock-enable generator
package pll_clk_en_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } lock_state_e;

    localparam int ACC_W_DEF       = 24;
    localparam int NUM_CH_DEF      = 4;
    localparam int LOCK_FILTER_DEF = 1024;

    // Width of a channel index; a single channel still needs a 1-bit select.
    function automatic int chan_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_clk_en_nco.sv
// rtl/pll_clk_en_nco.sv - one phase-accumulator channel with glitch-free increment update
module pll_clk_en_nco
    import pll_clk_en_pkg::*;
#(
    parameter int               ACC_W    = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INIT_INC = ACC_W'(24'h010000)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             advance_i,
    input  logic             clear_i,
    input  logic             wr_stb_i,
    input  logic [ACC_W-1:0] wr_inc_i,
    output logic             ce_o,
    output logic             pending_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             ce_q, ce_d;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             apply;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, inc_q};
        carry = advance_i && sum[ACC_W];

        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (advance_i) begin
            acc_d = sum[ACC_W-1:0];
        end

        ce_d = carry && !clear_i;

        // A new increment only takes over at a period boundary or while the channel is idle,
        // so no strobe interval is ever a blend of old and new rates.
        apply     = pending_q && (carry || !advance_i);
        inc_d     = apply ? shadow_q : inc_q;
        shadow_d  = wr_stb_i ? wr_inc_i : shadow_q;
        pending_d = wr_stb_i || (pending_q && !apply);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            inc_q     <= INIT_INC;
            shadow_q  <= INIT_INC;
            pending_q <= 1'b0;
            ce_q      <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            inc_q     <= inc_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ce_q      <= ce_d;
        end
    end

    assign ce_o      = ce_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/pll_clk_en_gen.sv
// rtl/pll_clk_en_gen.sv - multi-channel NCO clock-enable generator gated by filtered PLL lock
module pll_clk_en_gen
    import pll_clk_en_pkg::*;
#(
    parameter int               NUM_CH      = NUM_CH_DEF,
    parameter int               ACC_W       = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INIT_INC    = ACC_W'(24'h010000),
    parameter int               LOCK_FILTER = LOCK_FILTER_DEF,
    localparam int              CW          = chan_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_lock,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CW-1:0]     cfg_chan,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);

    localparam int             CNT_W    = $clog2(LOCK_FILTER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILTER - 1);

    logic              sync1_q, sync2_q;
    logic              lock_s;
    lock_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run;
    logic              clear;
    logic [NUM_CH-1:0] advance;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_stb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_lock;
            sync2_q <= sync1_q;
        end
    end

    assign lock_s = sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any synchronised lock drop restarts the whole filter from OFF.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!lock_s) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        run     = (state_q == ST_RUN);
        locked  = run;
        clear   = !lock_s;
        advance = (run && lock_s) ? chan_en : '0;
    end

    // Out-of-range channel indices match no channel, so they are always ready and ignored.
    always_comb begin
        cfg_ready = 1'b1;
        wr_stb    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_chan == CW'(i)) begin
                cfg_ready = !pending[i];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            wr_stb[i] = cfg_valid && cfg_ready && (cfg_chan == CW'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pll_clk_en_nco #(
            .ACC_W    (ACC_W),
            .INIT_INC (INIT_INC)
        ) u_nco (
            .clk_i     (clk),
            .rst_ni    (reset_n),
            .advance_i (advance[g]),
            .clear_i   (clear),
            .wr_stb_i  (wr_stb[g]),
            .wr_inc_i  (cfg_inc),
            .ce_o      (ce[g]),
            .pending_o (pending[g])
        );
    end

endmodule

// File: tb/tb_pll_clk_en_gen.sv
// tb/tb_pll_clk_en_gen.sv - bench for pll_clk_en_gen with a cycle-level arithmetic reference model
module tb_pll_clk_en_gen;

    localparam int NCH  = 3;
    localparam int AW   = 8;
    localparam int LF   = 16;
    localparam int MODV = 256;

    logic           clk;
    logic           reset_n;
    logic           pll_lock;
    logic [NCH-1:0] chan_en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_chan;
    logic [AW-1:0]  cfg_inc;
    logic [NCH-1:0] ce;
    logic           locked;

    int checks   = 0;
    int failures = 0;
    int m_checks = 0;
    int m_fails  = 0;

    pll_clk_en_gen #(
        .NUM_CH      (NCH),
        .ACC_W       (AW),
        .INIT_INC    (8'd64),
        .LOCK_FILTER (LF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pll_lock  (pll_lock),
        .chan_en   (chan_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_inc   (cfg_inc),
        .ce        (ce),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: lock history, count of consecutive stable lock cycles, integer phase per channel.
    int       m_h1 = 0, m_h2 = 0, m_stable = 0, m_cyc = 0;
    int       m_phase [NCH];
    int       m_inc [NCH];
    int       m_shadow [NCH];
    bit       m_pend [NCH];
    bit       m_ce [NCH];

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_phase[c] = 0; m_inc[c] = 64; m_shadow[c] = 64; m_pend[c] = 0; m_ce[c] = 0;
        end
        forever begin
            int       ls, chi, rdy, adv, carry, exp_rdy;
            bit       run_b;
            logic [NCH-1:0] exp_ce;
            @(posedge clk);
            m_cyc++;
            if (!reset_n) begin
                m_h1 = 0; m_h2 = 0; m_stable = 0;
                for (int c = 0; c < NCH; c++) begin
                    m_phase[c] = 0; m_inc[c] = 64; m_shadow[c] = 64; m_pend[c] = 0; m_ce[c] = 0;
                end
            end else begin
                ls = m_h2; m_h2 = m_h1; m_h1 = int'(pll_lock);
                run_b = (m_stable >= LF);
                chi = int'(cfg_chan);
                rdy = (chi >= NCH) ? 1 : (m_pend[chi] ? 0 : 1);
                for (int c = 0; c < NCH; c++) begin
                    adv = (run_b && ls != 0 && chan_en[c]) ? 1 : 0;
                    carry = 0;
                    if (adv != 0) begin
                        m_phase[c] = m_phase[c] + m_inc[c];
                        if (m_phase[c] >= MODV) begin
                            carry = 1;
                            m_phase[c] = m_phase[c] - MODV;
                        end
                    end else if (ls == 0) begin
                        m_phase[c] = 0;
                    end
                    m_ce[c] = (carry != 0);
                    if (m_pend[c] && (carry != 0 || adv == 0)) begin
                        m_inc[c] = m_shadow[c];
                        m_pend[c] = 0;
                    end
                    if (cfg_valid && rdy != 0 && chi == c) begin
                        m_shadow[c] = int'(cfg_inc);
                        m_pend[c] = 1;
                    end
                end
                if (ls == 0) m_stable = 0;
                else if (m_stable < LF) m_stable++;
            end
            #1;
            for (int c = 0; c < NCH; c++) exp_ce[c] = m_ce[c];
            chi = int'(cfg_chan);
            exp_rdy = (chi >= NCH) ? 1 : (m_pend[chi] ? 0 : 1);
            m_checks += 3;
            if (ce !== exp_ce) begin
                m_fails++;
                $display("FAIL model_ce cyc=%0d actual=%b expected=%b", m_cyc, ce, exp_ce);
            end
            if (locked !== (m_stable >= LF)) begin
                m_fails++;
                $display("FAIL model_locked cyc=%0d actual=%b expected=%0d", m_cyc, locked, m_stable >= LF);
            end
            if (int'(cfg_ready) != exp_rdy) begin
                m_fails++;
                $display("FAIL model_ready cyc=%0d actual=%b expected=%0d", m_cyc, cfg_ready, exp_rdy);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    function automatic logic probe(input int which);
        case (which)
            0: return ce[0];
            1: return ce[1];
            2: return ce[2];
            3: return locked;
            default: return !locked;
        endcase
    endfunction

    // Negedges until the probed condition holds; -1 when the budget runs out.
    task automatic wait_for(input int which, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (probe(which)) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic cfg_write(input int ch, input int val, output int stall);
        cfg_chan  = ch[1:0];
        cfg_inc   = val[7:0];
        cfg_valid = 1'b1;
        stall     = 0;
        #1;
        while (!cfg_ready && stall < 600) begin
            @(negedge clk);
            #1;
            stall++;
        end
        check("cfg_accept", int'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic count_ce(input int ch, input int cycles, output int highs);
        highs = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (ce[ch]) highs++;
        end
    endtask

    initial begin
        int n, s, hi, c8, dbl;
        logic prev;
        reset_n = 1'b0; pll_lock = 1'b0; chan_en = '1;
        cfg_valid = 1'b0; cfg_chan = 2'd0; cfg_inc = '0;
        repeat (3) @(negedge clk);
        check("rst_locked", int'(locked), 0);
        check("rst_ce", int'(ce), 0);
        check("rst_ready", int'(cfg_ready), 1);

        reset_n = 1'b1; pll_lock = 1'b1;
        wait_for(3, 100, n); check("lock_rise", n, 18);
        wait_for(0, 20, n);  check("first_ce", n, 4);
        wait_for(0, 20, n);  check("ce_period", n, 4);

        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        wait_for(4, 20, n);  check("glitch_fall", n, 2);
        check("glitch_ce", int'(ce), 0);
        wait_for(3, 100, n); check("relock_rise", n, 16);
        wait_for(0, 20, n);  check("relock_first_ce", n, 4);

        cfg_write(0, 96, s);
        repeat (20) @(negedge clk);
        hi = 0; c8 = 0; dbl = 0; prev = ce[0];
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (ce[0]) begin
                hi++;
                if (k < 8) c8++;
                if (prev) dbl++;
            end
            prev = ce[0];
        end
        check("frac_8", c8, 3);
        check("frac_64", hi, 24);
        check("frac_width", dbl, 0);

        cfg_write(0, 64, s);
        repeat (20) @(negedge clk);
        wait_for(0, 20, n);
        cfg_write(0, 128, s);
        check("upd_ready_ch0", int'(cfg_ready), 0);
        cfg_chan = 2'd1; #1;
        check("upd_ready_ch1", int'(cfg_ready), 1);
        cfg_chan = 2'd0;
        wait_for(0, 20, n);  check("upd_old_rate", n, 3);
        check("upd_ready_clear", int'(cfg_ready), 1);
        wait_for(0, 20, n);  check("upd_new_rate", n, 2);

        cfg_write(0, 64, s);
        cfg_write(0, 96, s); check("stall_cycles", s, 1);
        wait_for(0, 20, n);  check("stall_apply", n, 3);

        wait_for(1, 20, n);
        repeat (3) @(negedge clk);
        cfg_write(1, 128, s);
        check("carry_edge_ce", int'(ce[1]), 1);
        check("carry_edge_pending", int'(cfg_ready), 0);
        wait_for(1, 20, n);  check("carry_edge_old", n, 4);
        wait_for(1, 20, n);  check("carry_edge_new", n, 2);

        cfg_chan = 2'd3; #1;
        check("oor_ready", int'(cfg_ready), 1);
        cfg_write(3, 0, s);  check("oor_stall", s, 0);
        repeat (10) @(negedge clk);

        cfg_write(0, 0, s);
        repeat (10) @(negedge clk);
        count_ce(0, 1000, hi); check("inc0_no_ce", hi, 0);

        cfg_write(1, 255, s);
        repeat (10) @(negedge clk);
        count_ce(1, 256, hi); check("inc255_low_a", 256 - hi, 1);
        count_ce(1, 256, hi); check("inc255_low_b", 256 - hi, 1);

        cfg_write(0, 64, s);
        cfg_chan = 2'd0;
        repeat (10) @(negedge clk);
        check("inc0_pending_held", int'(cfg_ready), 0);
        chan_en[0] = 1'b0;
        @(negedge clk);
        check("idle_apply", int'(cfg_ready), 1);
        chan_en[0] = 1'b1;
        wait_for(0, 20, n);
        chan_en[0] = 1'b0;
        count_ce(0, 10, hi); check("hold_no_ce", hi, 0);
        chan_en[0] = 1'b1;
        wait_for(0, 20, n);  check("resume_phase", n, 4);

        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_rst_locked", int'(locked), 0);
        check("async_rst_ce", int'(ce), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_for(3, 100, n); check("rst_relock", n, 18);
        wait_for(0, 20, n);  check("rst_first_ce", n, 4);

        repeat (5) @(negedge clk);
        checks   += m_checks;
        failures += m_fails;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
